// File: rtl/spatial_encoder_param.sv
// HDC spatial encoder: binds item-memory and projection HVs per channel, accumulates
// per-dimension bit counts over a frame and thresholds them into a majority-vote HV.
module spatial_encoder_param #(
    parameter int HV_DIMENSION    = 2000,
    parameter int MAX_NUM_CHANNEL = 255,
    parameter int CH_W            = $clog2(MAX_NUM_CHANNEL + 1),
    parameter int ACC_W           = $clog2(MAX_NUM_CHANNEL + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CH_W-1:0]         num_channel,
    input  logic [1:0]              tie_mode,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [HV_DIMENSION-1:0] im,
    input  logic [HV_DIMENSION-1:0] projm,
    output logic                    hvout_valid,
    input  logic                    hvout_ready,
    output logic [HV_DIMENSION-1:0] hvout,
    output logic                    busy
);

    // All three handshakes transfer on a cycle where valid && ready at the rising edge;
    // a producer holds valid and its payload stable until that transfer happens.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_TIE    = 3'd2,
        S_THRESH = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    localparam logic [CH_W-1:0]  MAX_CH  = CH_W'(MAX_NUM_CHANNEL);
    localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
    localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);

    state_t                  state;
    logic [CH_W-1:0]         ns;
    logic [CH_W-1:0]         idx;
    logic [1:0]              mode;
    logic [ACC_W-1:0]        m;
    logic [HV_DIMENSION-1:0] first_hv;
    logic [HV_DIMENSION-1:0] last_hv;
    logic [ACC_W-1:0]        acc [HV_DIMENSION];

    logic                    cfg_fire;
    logic                    din_fire;
    logic                    out_fire;
    logic [CH_W-1:0]         ns_sel;
    logic [ACC_W-1:0]        ns_ext;
    logic [ACC_W-1:0]        half_m;
    logic [ACC_W-1:0]        half_ns;
    logic [ACC_W-1:0]        half_ns1;
    logic [HV_DIMENSION-1:0] bound_hv;
    logic [HV_DIMENSION-1:0] thresh_hv;

    assign cfg_fire = cfg_valid && cfg_ready;
    assign din_fire = din_valid && din_ready;
    assign out_fire = hvout_valid && hvout_ready;
    assign bound_hv = im ^ projm;

    always_comb begin
        ns_sel = (num_channel > MAX_CH) ? MAX_CH : num_channel;
    end

    // Threshold per dimension; mode 3 was folded into mode 0 when the frame was opened.
    always_comb begin
        ns_ext    = ACC_W'(ns);
        half_m    = m >> 1;
        half_ns   = ns_ext >> 1;
        half_ns1  = (ns_ext + ACC_ONE) >> 1;
        thresh_hv = '0;
        for (int i = 0; i < HV_DIMENSION; i++) begin
            case (mode)
                2'd1:    thresh_hv[i] = (acc[i] >  half_ns);
                2'd2:    thresh_hv[i] = (acc[i] >= half_ns1);
                default: thresh_hv[i] = (acc[i] >  half_m);
            endcase
        end
        // An empty frame always encodes to the all-zero HV, whatever the mode.
        if (ns == '0) begin
            thresh_hv = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cfg_ready   <= 1'b1;
            din_ready   <= 1'b0;
            hvout_valid <= 1'b0;
            busy        <= 1'b0;
            hvout       <= '0;
            ns          <= '0;
            idx         <= '0;
            mode        <= 2'd0;
            m           <= '0;
            first_hv    <= '0;
            last_hv     <= '0;
            for (int i = 0; i < HV_DIMENSION; i++) begin
                acc[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_fire) begin
                        ns        <= ns_sel;
                        mode      <= (tie_mode == 2'd3) ? 2'd0 : tie_mode;
                        idx       <= '0;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (ns_sel == '0) begin
                            state <= S_THRESH;
                        end else begin
                            state     <= S_ACCUM;
                            din_ready <= 1'b1;
                        end
                    end
                end

                S_ACCUM: begin
                    if (din_fire) begin
                        for (int i = 0; i < HV_DIMENSION; i++) begin
                            acc[i] <= acc[i] + {{(ACC_W-1){1'b0}}, bound_hv[i]};
                        end
                        idx <= idx + CH_ONE;
                        if (idx == '0) begin
                            first_hv <= bound_hv;
                        end
                        if (idx == ns - CH_ONE) begin
                            last_hv   <= bound_hv;
                            din_ready <= 1'b0;
                            state     <= S_TIE;
                        end
                    end
                end

                S_TIE: begin
                    // Even frames in XOR mode get one extra vote so the count is odd.
                    if (mode == 2'd0 && !ns[0]) begin
                        for (int i = 0; i < HV_DIMENSION; i++) begin
                            acc[i] <= acc[i] + {{(ACC_W-1){1'b0}}, first_hv[i] ^ last_hv[i]};
                        end
                        m <= ns_ext + ACC_ONE;
                    end else begin
                        m <= ns_ext;
                    end
                    state <= S_THRESH;
                end

                S_THRESH: begin
                    hvout       <= thresh_hv;
                    hvout_valid <= 1'b1;
                    state       <= S_OUT;
                end

                S_OUT: begin
                    if (out_fire) begin
                        hvout_valid <= 1'b0;
                        cfg_ready   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                        for (int i = 0; i < HV_DIMENSION; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spatial_encoder_param.sv
// Directed bench for spatial_encoder_param at HV_DIMENSION=8, MAX_NUM_CHANNEL=7.
module tb_spatial_encoder_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] num_channel;
    logic [1:0] tie_mode;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] im;
    logic [7:0] projm;
    logic       hvout_valid;
    logic       hvout_ready;
    logic [7:0] hvout;
    logic       busy;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] ch_im [7];

    spatial_encoder_param #(
        .HV_DIMENSION   (8),
        .MAX_NUM_CHANNEL(7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .num_channel(num_channel),
        .tie_mode   (tie_mode),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .im         (im),
        .projm      (projm),
        .hvout_valid(hvout_valid),
        .hvout_ready(hvout_ready),
        .hvout      (hvout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the config transfer.
    task automatic do_cfg(input logic [2:0] n, input logic [1:0] mode);
        int t = 0;
        num_channel = n;
        tie_mode    = mode;
        cfg_valid   = 1'b1;
        while (!cfg_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_ch(input logic [7:0] i, input logic [7:0] p);
        int t = 0;
        im        = i;
        projm     = p;
        din_valid = 1'b1;
        while (!din_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("din_ready_wait", {31'd0, din_ready}, 32'd1);
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int n, input logic [1:0] mode,
                             input logic [7:0] pm, input int gap, input int hold,
                             input logic [7:0] exp);
        int t;
        logic seen;
        if (n == 0) din_valid = 1'b1;
        do_cfg(3'(n), mode);
        for (int c = 0; c < n; c++) begin
            repeat (gap) @(negedge clk);
            send_ch(ch_im[c], pm);
        end
        if (n > 0) begin
            check({tag, "_lat0"}, {31'd0, hvout_valid}, 32'd0);
            @(negedge clk);
            check({tag, "_lat1"}, {31'd0, hvout_valid}, 32'd0);
            @(negedge clk);
            check({tag, "_lat2"}, {31'd0, hvout_valid}, 32'd1);
        end else begin
            t    = 0;
            seen = 1'b0;
            while (!hvout_valid && t < 10) begin
                if (din_ready) seen = 1'b1;
                @(negedge clk);
                t++;
            end
            din_valid = 1'b0;
            check({tag, "_no_din"}, {31'd0, seen}, 32'd0);
            check({tag, "_valid"}, {31'd0, hvout_valid}, 32'd1);
        end
        check({tag, "_hvout"}, {24'd0, hvout}, {24'd0, exp});
        hvout_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, hvout_valid}, 32'd1);
            check({tag, "_hold_data"}, {24'd0, hvout}, {24'd0, exp});
            check({tag, "_hold_cfg_ready"}, {31'd0, cfg_ready}, 32'd0);
            check({tag, "_hold_busy"}, {31'd0, busy}, 32'd1);
        end
        hvout_ready = 1'b1;
        @(negedge clk);
        hvout_ready = 1'b0;
        check({tag, "_drop_valid"}, {31'd0, hvout_valid}, 32'd0);
        check({tag, "_cfg_back"}, {31'd0, cfg_ready}, 32'd1);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_kept"}, {24'd0, hvout}, {24'd0, exp});
    endtask

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        num_channel = 3'd0;
        tie_mode    = 2'd0;
        din_valid   = 1'b0;
        im          = 8'h00;
        projm       = 8'h00;
        hvout_ready = 1'b0;
        for (int c = 0; c < 7; c++) ch_im[c] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_hvout_valid", {31'd0, hvout_valid}, 32'd0);
        check("rst_hvout", {24'd0, hvout}, 32'd0);
        check("rst_din_ready", {31'd0, din_ready}, 32'd0);
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        ch_im[0] = 8'hF0; ch_im[1] = 8'hCC; ch_im[2] = 8'hAA;
        run_frame("odd_m1", 3, 2'd1, 8'h00, 0, 0, 8'hE8);
        run_frame("tie_m0", 2, 2'd0, 8'h00, 0, 0, 8'hFC);
        run_frame("tie_m1", 2, 2'd1, 8'h00, 0, 0, 8'hC0);
        run_frame("tie_m2", 2, 2'd2, 8'h00, 0, 1, 8'hFC);
        run_frame("tie_m3", 2, 2'd3, 8'h00, 0, 0, 8'hFC);

        ch_im[0] = 8'hA5;
        run_frame("bind", 1, 2'd0, 8'hFF, 2, 5, 8'h5A);

        run_frame("zero", 0, 2'd2, 8'h00, 0, 0, 8'h00);

        for (int c = 0; c < 7; c++) ch_im[c] = 8'hFF;
        run_frame("max", 7, 2'd0, 8'h00, 0, 0, 8'hFF);

        // Abort a frame after two of three channels.
        do_cfg(3'd3, 2'd1);
        send_ch(8'hF0, 8'h00);
        send_ch(8'hCC, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hvout_valid", {31'd0, hvout_valid}, 32'd0);
        check("abort_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("abort_din_ready", {31'd0, din_ready}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        ch_im[0] = 8'h3C;
        run_frame("after_abort", 1, 2'd1, 8'h00, 0, 0, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spatial_encoder_param.md
Name: spatial_encoder_param

Overview:
Parametrised next-generation HDC spatial encoder with selectable tie-break mode and proper streaming handshakes. It binds an item-memory HV with a projection HV per channel (XOR), accumulates each dimension over a configurable number of channels, then thresholds the counts into a majority-vote output HV. It sits between the IM/projection memory readout and the temporal encoder. A config handshake opens each frame, a per-channel valid/ready stream carries the data, and a held output handshake returns the result.

Parameters:
HV_DIMENSION, 2000, hypervector width in bits
MAX_NUM_CHANNEL, 255, largest channel count accepted per frame
CH_W, $clog2(MAX_NUM_CHANNEL+1), width of num_channel (derived)
ACC_W, $clog2(MAX_NUM_CHANNEL+2), per-dimension accumulator width (derived; holds N+1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_valid  in  1  frame config valid
cfg_ready  out  1  high only in IDLE
num_channel  in  CH_W  channels in this frame; sampled on cfg fire
tie_mode  in  2  0=XOR tie-break HV, 1=ties->0, 2=ties->1, 3=treated as 0; sampled on cfg fire
din_valid  in  1  channel data valid
din_ready  out  1  high only in ACCUM
im  in  HV_DIMENSION  item-memory HV for current channel
projm  in  HV_DIMENSION  projection HV for current channel
hvout_valid  out  1  result valid; held until fire
hvout_ready  in  1  downstream ready
hvout  out  HV_DIMENSION  encoded spatial HV; stable while hvout_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE. hvout_valid=0, hvout=0, din_ready=0, cfg_ready=1, busy=0. Accumulators, counters and tie register are cleared. Reset during any state aborts the frame with no output.
- States: IDLE -> ACCUM -> TIE -> THRESH -> OUT -> IDLE.
- IDLE: on cfg fire, latch Ns = min(num_channel, MAX_NUM_CHANNEL) and the mode, and clear the channel index.
  - If Ns==0, go to THRESH with all accumulators at 0. Result hvout=0.
  - Otherwise go to ACCUM.
- ACCUM:
  - b = im ^ projm.
  - On each din fire: acc[i] += b[i] for every dimension and increment the channel index.
  - On the first fire (idx 0), first_hv <= b.
  - On the fire with idx==Ns-1, last_hv <= b and go to TIE.
  - No fire means no change. din_valid is ignored outside ACCUM.
- TIE: always exactly one cycle.
  - Mode 0 with Ns even: acc[i] += (first_hv[i]^last_hv[i]) and M = Ns+1.
  - All other cases: no add and M = Ns.
  - For Ns==1, first_hv==last_hv.
- THRESH: one cycle. hvout[i] is registered as:
  - mode 0: acc[i] > (M>>1)
  - mode 1: acc[i] > (Ns>>1)
  - mode 2: acc[i] >= ((Ns+1)>>1)
  - The comparison is unsigned at ACC_W bits and cannot overflow (acc <= Ns+1).
- OUT: hvout_valid=1 and hvout is held.
  - On hvout fire: go to IDLE, drop hvout_valid the next cycle, and clear the accumulators.
  - cfg_ready returns the cycle after the fire, so there is no same-cycle back-to-back frame.
- Latency: the last din fire is at edge E. TIE completes at E+1 and THRESH at E+2, so hvout_valid is high from E+2. This is independent of HV_DIMENSION and Ns.
- Per-channel throughput: 1 channel/cycle under continuous din_valid.
- Mode 3 behaves identically to mode 0.
- hvout keeps its last value after the fire until the next THRESH.

Test Plan:
All scenarios use HV_DIMENSION=8, MAX_NUM_CHANNEL=7 and projm=0 unless stated.
- Odd majority: mode 1, Ns=3, im=F0,CC,AA -> hvout=E8, hvout_valid exactly 2 cycles after the third din fire.
- XOR tie-break: mode 0, Ns=2, im=F0,CC -> tie HV 3C added, M=3 -> hvout=FC.
- Tie modes: mode 1, Ns=2, im=F0,CC -> C0. The same stream in mode 2 -> FC. Mode 3 gives the mode 0 result FC.
- Binding and backpressure: Ns=1, im=A5, projm=FF, with din_valid gaps and hvout_ready held low 5 cycles -> hvout=5A, stable and valid for all 5 cycles, then cfg_ready high the cycle after the fire.
- Boundaries: Ns=0 -> hvout=00 with no din accepted. num_channel=9 (CH_W=3 wraps, so drive 7=max) with 7 channels of FF -> hvout=FF.
- Reset mid-frame: rst asserted after 2 of 3 channels -> hvout_valid=0, cfg_ready=1 next cycle. A following Ns=1 frame with im=3C -> hvout=3C, showing no stale accumulation.
